// File: rtl/wav_gen_pkg.sv
// Shared constants for the DDS waveform source and its downstream selector.
// Quadrant encoding and quarter-wave ROM address folding live here.
package wav_pkg;

  localparam logic [7:0] MIDSCALE     = 8'd128;
  localparam int         LUT_AW       = 6;
  localparam int         DEF_TICK_DIV = 2083;
  localparam int         DEF_PHASE_W  = 24;

  typedef enum logic [1:0] {
    QUAD_POS_RISE = 2'd0,
    QUAD_POS_FALL = 2'd1,
    QUAD_NEG_FALL = 2'd2,
    QUAD_NEG_RISE = 2'd3
  } quad_e;

  // Odd quadrants walk the quarter wave backwards: 63 - idx is ~idx in 6 bits.
  function automatic logic [LUT_AW-1:0] rom_addr(input quad_e quad, input logic [LUT_AW-1:0] idx);
    case (quad)
      QUAD_POS_RISE, QUAD_NEG_FALL: rom_addr = idx;
      QUAD_POS_FALL, QUAD_NEG_RISE: rom_addr = ~idx;
      default:                      rom_addr = idx;
    endcase
  endfunction

endpackage

// File: rtl/wav_gen_sine_rom.sv
// Quarter-wave sine table, 64 x 7 bit, rom[i] = round(127*sin(2*pi*i/256)).
// Registered output, no reset: contents are constant.
module sine_rom
  import wav_pkg::*;
(
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr,
  output logic [6:0]        q
);

  logic [6:0] q_d;
  logic [6:0] q_q;

  always_comb begin
    q_d = 7'd0;
    case (addr)
      6'd0:  q_d = 7'd0;   6'd1:  q_d = 7'd3;   6'd2:  q_d = 7'd6;   6'd3:  q_d = 7'd9;
      6'd4:  q_d = 7'd12;  6'd5:  q_d = 7'd16;  6'd6:  q_d = 7'd19;  6'd7:  q_d = 7'd22;
      6'd8:  q_d = 7'd25;  6'd9:  q_d = 7'd28;  6'd10: q_d = 7'd31;  6'd11: q_d = 7'd34;
      6'd12: q_d = 7'd37;  6'd13: q_d = 7'd40;  6'd14: q_d = 7'd43;  6'd15: q_d = 7'd46;
      6'd16: q_d = 7'd49;  6'd17: q_d = 7'd51;  6'd18: q_d = 7'd54;  6'd19: q_d = 7'd57;
      6'd20: q_d = 7'd60;  6'd21: q_d = 7'd63;  6'd22: q_d = 7'd65;  6'd23: q_d = 7'd68;
      6'd24: q_d = 7'd71;  6'd25: q_d = 7'd73;  6'd26: q_d = 7'd76;  6'd27: q_d = 7'd78;
      6'd28: q_d = 7'd81;  6'd29: q_d = 7'd83;  6'd30: q_d = 7'd85;  6'd31: q_d = 7'd88;
      6'd32: q_d = 7'd90;  6'd33: q_d = 7'd92;  6'd34: q_d = 7'd94;  6'd35: q_d = 7'd96;
      6'd36: q_d = 7'd98;  6'd37: q_d = 7'd100; 6'd38: q_d = 7'd102; 6'd39: q_d = 7'd104;
      6'd40: q_d = 7'd106; 6'd41: q_d = 7'd107; 6'd42: q_d = 7'd109; 6'd43: q_d = 7'd111;
      6'd44: q_d = 7'd112; 6'd45: q_d = 7'd113; 6'd46: q_d = 7'd115; 6'd47: q_d = 7'd116;
      6'd48: q_d = 7'd117; 6'd49: q_d = 7'd118; 6'd50: q_d = 7'd120; 6'd51: q_d = 7'd121;
      6'd52: q_d = 7'd122; 6'd53: q_d = 7'd122; 6'd54: q_d = 7'd123; 6'd55: q_d = 7'd124;
      6'd56: q_d = 7'd125; 6'd57: q_d = 7'd125; 6'd58: q_d = 7'd126; 6'd59: q_d = 7'd126;
      6'd60: q_d = 7'd126; 6'd61: q_d = 7'd127; 6'd62: q_d = 7'd127; 6'd63: q_d = 7'd127;
      default: q_d = 7'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/wav_gen.sv
// DDS source: prescaler, phase accumulator and a two-stage pipeline producing
// sine, triangle and square samples that all share one phase.
module wav_gen
  import wav_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int PHASE_W  = DEF_PHASE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] tune,
  input  logic [7:0]         duty,
  output logic [7:0]         sine_out,
  output logic [7:0]         triangle_out,
  output logic [7:0]         square_out,
  output logic               sample_valid
);

  localparam int               CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [PHASE_W-1:0] phase_d, phase_q;
  logic               v0_d, v0_q;
  logic               v1_d, v1_q;
  logic [7:0]         p8_dly_d, p8_dly_q;
  logic [7:0]         sine_d, sine_q;
  logic [7:0]         tri_d, tri_q;
  logic [7:0]         sq_d, sq_q;
  logic               valid_d, valid_q;

  logic               tick_s;
  logic               adv_s;
  logic [7:0]         p8_s;
  logic [LUT_AW-1:0]  rom_addr_s;
  logic [6:0]         rom_q_s;
  logic [7:0]         tri_raw_s;

  assign p8_s       = phase_q[PHASE_W-1 -: 8];
  assign rom_addr_s = rom_addr(quad_e'(p8_s[7:6]), p8_s[LUT_AW-1:0]);

  sine_rom u_sine_rom (
    .clk  (clk),
    .addr (rom_addr_s),
    .q    (rom_q_s)
  );

  // The prescaler free-runs; en only gates whether a tick advances the phase.
  always_comb begin
    tick_s   = (cnt_q == CNT_LAST);
    adv_s    = tick_s & en;
    cnt_d    = tick_s ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
    phase_d  = adv_s ? phase_q + tune : phase_q;
    v0_d     = adv_s;
    v1_d     = v0_q;
    p8_dly_d = v0_q ? p8_s : p8_dly_q;
    valid_d  = v1_q;
  end

  always_comb begin
    tri_raw_s = {p8_dly_q[6:0], 1'b0};
    if (v1_q) begin
      if (p8_dly_q[7]) begin
        sine_d = 8'd127 - {1'b0, rom_q_s};
        tri_d  = ~tri_raw_s;
      end else begin
        sine_d = MIDSCALE + {1'b0, rom_q_s};
        tri_d  = tri_raw_s;
      end
      sq_d = (p8_dly_q < duty) ? 8'hFF : 8'h00;
    end else begin
      sine_d = sine_q;
      tri_d  = tri_q;
      sq_d   = sq_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= {CNT_W{1'b0}};
      phase_q  <= {PHASE_W{1'b0}};
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      p8_dly_q <= 8'd0;
      sine_q   <= MIDSCALE;
      tri_q    <= 8'd0;
      sq_q     <= 8'd0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      p8_dly_q <= p8_dly_d;
      sine_q   <= sine_d;
      tri_q    <= tri_d;
      sq_q     <= sq_d;
      valid_q  <= valid_d;
    end
  end

  assign sine_out     = sine_q;
  assign triangle_out = tri_q;
  assign square_out   = sq_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_wav_gen.sv
// Scoreboard bench for wav_gen (TICK_DIV=4, PHASE_W=8): stimulus pushes expected
// triplets with their due edge; a negedge monitor pops and compares them.
module tb_wav_gen;

  localparam real PI = 3.14159265358979;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic [7:0] tune = 8'd5;
  logic [7:0] duty = 8'd128;
  logic [7:0] sine_out, triangle_out, square_out;
  logic       sample_valid;

  always #5 clk = ~clk;

  wav_gen #(.TICK_DIV(4), .PHASE_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .tune         (tune),
    .duty         (duty),
    .sine_out     (sine_out),
    .triangle_out (triangle_out),
    .square_out   (square_out),
    .sample_valid (sample_valid)
  );

  typedef struct {
    logic [7:0] p8;
    logic [7:0] s;
    logic [7:0] t;
    logic [7:0] q;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  int         n_total = 0;
  int         n_pass = 0;
  int         edge_n = 0;
  int         m_cnt = 0;
  logic [7:0] m_phase = 8'd0;
  logic       mon_on = 1'b0;
  logic [7:0] held_s = 8'd128;
  logic [7:0] held_t = 8'd0;
  logic [7:0] held_q = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d (edge %0d)", name, act, req, edge_n);
  endtask

  function automatic int ref_rom(input int i);
    return $rtoi(127.0 * $sin(2.0 * PI * i / 256.0) + 0.5);
  endfunction

  // Quarter-wave reconstruction as the sine output is defined.
  function automatic logic [7:0] exp_sine(input logic [7:0] p8);
    int p, idx, addr, r;
    p    = int'(p8);
    idx  = p % 64;
    addr = (((p / 64) % 2) == 1) ? 63 - idx : idx;
    r    = ref_rom(addr);
    return (p >= 128) ? 8'(127 - r) : 8'(128 + r);
  endfunction

  function automatic logic [7:0] exp_tri(input logic [7:0] p8);
    int p;
    p = int'(p8);
    return (p < 128) ? 8'(2 * p) : 8'(511 - 2 * p);
  endfunction

  // One clock edge plus the reference model of prescaler and accumulator.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    edge_n++;
    if (!rst) begin
      m_cnt   = 0;
      m_phase = 8'd0;
      sbq.delete();
      held_s  = 8'd128;
      held_t  = 8'd0;
      held_q  = 8'd0;
      mon_on  = 1'b1;
    end else if (m_cnt == 3) begin
      m_cnt = 0;
      if (en) begin
        m_phase = m_phase + tune;
        e.p8  = m_phase;
        e.s   = exp_sine(m_phase);
        e.t   = exp_tri(m_phase);
        e.q   = (m_phase < duty) ? 8'hFF : 8'h00;
        e.due = edge_n + 2;
        sbq.push_back(e);
      end
    end else begin
      m_cnt++;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_tick();
    cyc();
    while (m_cnt != 0) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    cyc();
  endtask

  // Monitor: compare each valid triplet, and check outputs hold otherwise.
  initial begin
    exp_t       e;
    logic [7:0] hs, ht;
    logic       hv;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (sample_valid) begin
          if (sbq.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("valid_edge", edge_n, e.due);
            chk("sine", sine_out, e.s);
            chk("triangle", triangle_out, e.t);
            chk("square", square_out, e.q);
            held_s = e.s;
            held_t = e.t;
            held_q = e.q;
            hv = 1'b1;
            case (e.p8)
              8'd0:    begin hs = 8'd128; ht = 8'd0;   end
              8'd5:    begin hs = 8'd144; ht = 8'd10;  end
              8'd64:   begin hs = 8'd255; ht = 8'd128; end
              8'd127:  begin hs = 8'd128; ht = 8'd254; end
              8'd128:  begin hs = 8'd127; ht = 8'd255; end
              8'd144:  begin hs = 8'd78;  ht = 8'd223; end
              8'd192:  begin hs = 8'd0;   ht = 8'd127; end
              8'd200:  begin hs = 8'd3;   ht = 8'd111; end
              8'd255:  begin hs = 8'd127; ht = 8'd1;   end
              default: begin hs = 8'd0;   ht = 8'd0; hv = 1'b0; end
            endcase
            if (hv) begin
              chk("hand_sine", sine_out, hs);
              chk("hand_triangle", triangle_out, ht);
            end
          end
        end else begin
          chk("hold_outputs", {8'd0, sine_out, triangle_out, square_out},
              {8'd0, held_s, held_t, held_q});
          if (sbq.size() != 0 && sbq[0].due <= edge_n) begin
            chk("missing_valid", 32'd0, 32'd1);
            void'(sbq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    // Reset held for three edges, then first sample at phase 5.
    rst = 1'b0; en = 1'b1; tune = 8'd5; duty = 8'd128;
    run(3);
    rst = 1'b1;
    run(8);

    // Full sweep, one tick per LSB of phase.
    tune = 8'd1;
    run(256 * 4);

    // Wrap from 200 to 144, then tune wiggled between ticks.
    do_reset();
    rst = 1'b1;
    tune = 8'd200;
    run(8);
    for (int i = 0; i < 8; i++) begin
      tune = 8'(50 + 3 * i);
      cyc();
    end
    run(4);

    // en gating with a sample already in flight.
    tune = 8'd3;
    wait_tick();
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(12);

    // Reset one cycle after a tick flushes that sample.
    wait_tick();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    tune = 8'd1;
    run(12);

    // Duty extremes over a full sweep each.
    do_reset();
    duty = 8'd0;
    rst = 1'b1;
    run(256 * 4);
    do_reset();
    duty = 8'd255;
    rst = 1'b1;
    run(256 * 4 + 4);

    en = 1'b0;
    run(6);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wav_gen.md
Name: wav_gen

Overview:
- Direct-digital-synthesis source feeding the waveform selector. It produces the three unsigned 8-bit streams consumed as sine_in, triangle_in and square_in.
- Built from a sample-rate prescaler, a phase accumulator, a quarter-wave sine ROM and the triangle/square derivation.
- All three outputs share one phase, so switching waveform downstream is phase-continuous.
- Output code 128 is DAC midscale for the R2R ladder.

Parameters:
- TICK_DIV, 2083: clk cycles per sample tick (100 MHz / 2083 ≈ 48.008 kHz); legal range ≥ 2.
- PHASE_W, 24: phase accumulator width; legal range ≥ 8.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low; sampled on the clk rising edge.
- en  in  1  1 = generate samples; 0 = freeze phase and outputs.
- tune  in  PHASE_W  phase increment per tick; f_out = tune*Fs/2^PHASE_W.
- duty  in  8  square high-time threshold; 128 = 50 %.
- sine_out  out  8  unsigned sine, registered.
- triangle_out  out  8  unsigned triangle, registered.
- square_out  out  8  0xFF or 0x00, registered.
- sample_valid  out  1  one-cycle strobe; new output triplet present in this cycle.

Behaviour:
- Reset (rst=0 at an edge) sets:
  - prescaler count=0, phase=0, pipeline valid bits=0;
  - sine_out=128, triangle_out=0, square_out=0, sample_valid=0.
- Reset mid-pipeline flushes the in-flight sample; no sample_valid for it.
- Prescaler:
  - cnt counts 0..TICK_DIV-1 and wraps;
  - tick=1 exactly in the cycle cnt==TICK_DIV-1;
  - the prescaler runs regardless of en.
- Accumulator: on an edge with tick=1 and en=1, phase <= phase + tune, mod 2^PHASE_W.
  - tune is sampled only at that edge; changes between ticks have no effect.
  - tune=0: phase holds, and the same triplet is re-emitted with sample_valid every tick.
  - No aliasing guard for large tune.
- en=0: ticks are ignored; phase, outputs and sample_valid are frozen (sample_valid=0).
  - Samples already in the pipeline still complete.
- Pipeline, with tick+en seen at edge E0:
  - E1: p8 = phase[PHASE_W-1 -: 8] decoded into quadrant q=p8[7:6] and idx=p8[5:0].
    - ROM address = idx when q[0]=0, else 63-idx.
    - rom_q <= rom[addr], p8_d <= p8, v1 <= 1.
  - E2: outputs are updated from rom_q and p8_d; sample_valid <= v1, and v1 clears.
  - sample_valid is high for the single cycle after E2; the outputs then hold until the next update.
  - Latency from the tick cycle to the valid cycle is 3 cycles.
- Sine:
  - ROM contents: rom[i] = round(127*sin(2*pi*i/256)), i=0..63, values 0..127.
  - sine_out = 128 + rom_q when p8_d[7]=0, else 127 - rom_q. Range 0..255 with no overflow.
- Triangle:
  - p8_d[7]=0: triangle_out = {p8_d[6:0],0};
  - p8_d[7]=1: triangle_out = ~{p8_d[6:0],0}.
  - p8=0 → 0; 127 → 254; 128 → 255; 255 → 1.
- Square: square_out = 0xFF if p8_d < duty, else 0x00.
  - duty=0 → always 0x00; duty=255 → 0x00 only at p8=255.
- Simultaneous events: rst=0 dominates tick/en. A tick that coincides with a reset edge is lost.

Decomposition:
- Shared package wav_pkg holds:
  - MIDSCALE = 8'd128;
  - LUT_AW = 6;
  - the quadrant encoding constants;
  - the default TICK_DIV and PHASE_W, which the selector and top level reuse.
- One sub-module, sine_rom: 64x7-bit ROM with a registered output, interface clk, addr[5:0], q[6:0], no reset.
  - The accumulator, prescaler and output stage stay in wav_gen.

Test Plan (bench uses TICK_DIV=4, PHASE_W=8):
- Reset: hold rst=0 for 3 cycles, en=1, tune=5 → sine_out=128, triangle_out=0, square_out=0, sample_valid=0 throughout; the first sample_valid arrives 3 cycles after the first tick following release, with sine=128+rom[5].
- Sweep: tune=1, duty=128, run 256 ticks → sine_out values are 128, 255, 127, 0 at p8=0, 64, 128, 192; triangle peaks at 255 (p8=128); square is 0xFF for p8<128 and 0x00 otherwise; exactly one sample_valid per tick, spaced 4 cycles apart.
- Wrap and tune change: tune=200 for 2 ticks → phase 200 then 144 (mod 256); tune changed mid-interval → not applied until the next tick edge.
- en gating: deassert en for 10 cycles → no sample_valid and outputs frozen; an in-flight sample still completes once; phase resumes from the held value.
- Mid-pipeline reset: assert rst=0 one cycle after a tick → no sample_valid for that sample, outputs return to 128/0/0, phase=0.
- Duty edges: duty=0 → square_out stays 0x00; duty=255, tune=1 → square_out is 0x00 only at p8=255.
